// File: rtl/sig_rom_arb_pkg.sv
// Shared constants, grant record and round-robin search for sig_rom_arbiter.
package sig_rom_arb_pkg;

  localparam int unsigned NUM_REQ_DEFAULT    = 4;
  localparam int unsigned IN_WIDTH_DEFAULT   = 10;
  localparam int unsigned DATA_WIDTH_DEFAULT = 16;
  localparam int unsigned ID_W               = $clog2(NUM_REQ_DEFAULT);

  // Search logic is sized for the largest supported requester count.
  localparam int unsigned MAX_REQ  = 16;
  localparam int unsigned MAX_ID_W = 4;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] idx;
    logic [MAX_REQ-1:0]  onehot;
  } grant_t;

  // First asserted req at or after ptr+1, wrapping modulo num.
  function automatic grant_t next_grant(input logic [MAX_REQ-1:0]  req,
                                        input logic [MAX_ID_W-1:0] ptr,
                                        input int unsigned         num);
    grant_t      g;
    int unsigned idx;
    g = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % num;
      if (k <= num && !g.valid && req[idx[MAX_ID_W-1:0]]) begin
        g.valid  = 1'b1;
        g.idx    = idx[MAX_ID_W-1:0];
        g.onehot = MAX_REQ'(1) << idx;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/sig_rom.sv
// Sigmoid lookup ROM with a registered address; data is valid the cycle after x is presented.
module sig_rom #(
  parameter int unsigned inWidth   = 10,
  parameter int unsigned dataWidth = 16
) (
  input  logic                 clk,
  input  logic [inWidth-1:0]   x,
  output logic [dataWidth-1:0] data
);

  logic [inWidth-1:0] addr_q;

  // Signed x to table index: flipping the MSB maps -2^(n-1)..2^(n-1)-1 onto 0..2^n-1.
  always_ff @(posedge clk) begin
    addr_q <= {~x[inWidth-1], x[inWidth-2:0]};
  end

  // Table contents: a monotone ramp over the index standing in for the sigmoid curve.
  if (dataWidth >= inWidth) begin : g_wide
    assign data = dataWidth'(addr_q) << (dataWidth - inWidth);
  end else begin : g_narrow
    logic unused_lsb;
    assign data       = addr_q[inWidth-1 -: dataWidth];
    assign unused_lsb = ^addr_q[inWidth-dataWidth-1:0];
  end

endmodule

// File: rtl/sig_rom_arbiter.sv
// Shares one sig_rom among NUM_REQ requesters; one grant per cycle, result 2 cycles later.
// Define SIG_ROM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sig_rom_arbiter
  import sig_rom_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEFAULT,
  parameter int unsigned inWidth   = IN_WIDTH_DEFAULT,
  parameter int unsigned dataWidth = DATA_WIDTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*inWidth-1:0]   x_in,
  output logic [NUM_REQ-1:0]           ack,
  output logic [NUM_REQ-1:0]           out_valid,
  output logic [NUM_REQ*dataWidth-1:0] out_data,
  output logic                         busy
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  grant_t              gnt;
  logic                grant_ok;
  logic [MAX_ID_W-1:0] ptr_cur;
  logic [inWidth-1:0]  rom_x;
  logic [dataWidth-1:0] rom_data;
  logic                stage_valid_q;
  logic [IdW-1:0]      stage_id_q;

`ifdef SIG_ROM_ARB_FIXED_PRIO_EN
  // Searching from NUM_REQ-1 makes index 0 the first candidate every cycle.
  assign ptr_cur = MAX_ID_W'(NUM_REQ - 1);
`else
  logic [IdW-1:0] rr_ptr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= IdW'(NUM_REQ - 1);
    end else if (grant_ok) begin
      rr_ptr_q <= gnt.idx[IdW-1:0];
    end
  end

  assign ptr_cur = MAX_ID_W'(rr_ptr_q);
`endif

  assign gnt      = next_grant(MAX_REQ'(req), ptr_cur, NUM_REQ);
  assign grant_ok = rst_n & gnt.valid;
  assign ack      = rst_n ? gnt.onehot[NUM_REQ-1:0] : '0;
  assign rom_x    = x_in[gnt.idx*inWidth +: inWidth];
  assign busy     = stage_valid_q;

  if (NUM_REQ < MAX_REQ) begin : g_unused
    logic unused_onehot;
    assign unused_onehot = ^gnt.onehot[MAX_REQ-1:NUM_REQ];
  end

  sig_rom #(
    .inWidth  (inWidth),
    .dataWidth(dataWidth)
  ) u_sig_rom (
    .clk (clk),
    .x   (rom_x),
    .data(rom_data)
  );

  // The ROM address register has no reset; stage_valid_q alone qualifies its output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_valid_q <= 1'b0;
      stage_id_q    <= '0;
      out_valid     <= '0;
      out_data      <= '0;
    end else begin
      stage_valid_q <= grant_ok;
      if (grant_ok) begin
        stage_id_q <= gnt.idx[IdW-1:0];
      end
      out_valid <= '0;
      if (stage_valid_q) begin
        out_valid[stage_id_q]                        <= 1'b1;
        out_data[stage_id_q*dataWidth +: dataWidth] <= rom_data;
      end
    end
  end

endmodule
